// File: rtl/pes_demux_pkg.sv
// Shared constants for the demux sequencer slice: channel count, select width, FSM encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package pes_demux_pkg;

    localparam int NUM_CH = 8;
    localparam int SEL_W  = 3;

    // FSM encoding kept as plain constants so older blocks can share it
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_LAST = 2'd2;

endpackage

// File: rtl/pes_demux_sequencer_if.sv
// Control/data bundle between a sequencer user (master) and the sequencer (slave).
// Latency: n/a (wiring only).
// Backpressure: none; commands are level-sampled, status is presented every cycle.
interface pes_demux_sequencer_if #(
    parameter int DWELL_W = 8
);
    import pes_demux_pkg::*;

    logic                 start;
    logic                 stop;
    logic [NUM_CH-1:0]    chan_en;
    logic [DWELL_W-1:0]   dwell;
    logic                 i;
    logic [SEL_W-1:0]     sel;
    logic [NUM_CH-1:0]    o;
    logic                 busy;
    logic                 slot_start;
    logic                 sweep_done;

    modport master (
        output start, stop, chan_en, dwell, i,
        input  sel, o, busy, slot_start, sweep_done
    );

    modport slave (
        input  start, stop, chan_en, dwell, i,
        output sel, o, busy, slot_start, sweep_done
    );

endinterface

// File: rtl/pes_demux_1_8.sv
// 1-to-8 demultiplexer: routes i to the output selected by sel, others held low.
// Latency: combinational.
// Backpressure: none.
module pes_demux_1_8 (
    input  logic [2:0] sel,
    input  logic       i,
    output logic       o0,
    output logic       o1,
    output logic       o2,
    output logic       o3,
    output logic       o4,
    output logic       o5,
    output logic       o6,
    output logic       o7
);

    assign o0 = i & (sel == 3'd0);
    assign o1 = i & (sel == 3'd1);
    assign o2 = i & (sel == 3'd2);
    assign o3 = i & (sel == 3'd3);
    assign o4 = i & (sel == 3'd4);
    assign o5 = i & (sel == 3'd5);
    assign o6 = i & (sel == 3'd6);
    assign o7 = i & (sel == 3'd7);

endmodule

// File: rtl/pes_demux_rr_pick.sv
// Finds the first enabled channel after cur (wrapping 7->0, cur itself checked last).
// Latency: combinational.
// Backpressure: none.
module pes_demux_rr_pick
    import pes_demux_pkg::*;
(
    input  logic [NUM_CH-1:0] mask,
    input  logic [SEL_W-1:0]  cur,
    output logic [SEL_W-1:0]  nxt_idx,
    output logic              found,
    output logic              wrapped
);

    logic [SEL_W-1:0] idx;

    // Scan farthest-first so the nearest enabled successor overwrites and wins
    always_comb begin
        nxt_idx = cur;
        found   = 1'b0;
        idx     = cur;
        for (int k = NUM_CH; k >= 1; k--) begin
            idx = cur + SEL_W'(k);
            if (mask[idx]) begin
                nxt_idx = idx;
                found   = 1'b1;
            end
        end
        wrapped = found && (nxt_idx <= cur);
    end

endmodule

// File: rtl/pes_demux_sequencer.sv
// Round-robin slot scheduler driving the 1:8 demux select, skipping masked channels.
// Latency: start -> busy/sel/slot_start next cycle; o is combinational from i.
// Backpressure: none; stop drains the current slot, redundant commands are dropped.
module pes_demux_sequencer
    import pes_demux_pkg::*;
#(
    parameter int DWELL_W = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    pes_demux_sequencer_if.slave  bus
);

    logic [1:0]         state;
    logic [SEL_W-1:0]   sel_q;
    logic [DWELL_W-1:0] count;
    logic [DWELL_W-1:0] dwell_q;
    logic               slot_start_q;

    logic               busy;
    logic               slot_last;
    logic [SEL_W-1:0]   pick_cur;
    logic [SEL_W-1:0]   pick_nxt;
    logic               pick_found;
    logic               pick_wrapped;

    assign busy      = (state != ST_IDLE);
    assign slot_last = busy && (count == dwell_q);

    // From IDLE, searching after channel 7 yields the lowest set bit
    assign pick_cur = busy ? sel_q : SEL_W'(NUM_CH - 1);

    pes_demux_rr_pick u_pick (
        .mask    (bus.chan_en),
        .cur     (pick_cur),
        .nxt_idx (pick_nxt),
        .found   (pick_found),
        .wrapped (pick_wrapped)
    );

    // Slot FSM: counts dwell, advances to next enabled channel, handles stop/mask-clear
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= ST_IDLE;
            sel_q        <= '0;
            count        <= '0;
            dwell_q      <= '0;
            slot_start_q <= 1'b0;
        end else begin
            slot_start_q <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (bus.start && pick_found) begin
                        state        <= ST_RUN;
                        sel_q        <= pick_nxt;
                        count        <= '0;
                        dwell_q      <= bus.dwell;
                        slot_start_q <= 1'b1;
                    end
                end
                ST_RUN: begin
                    if (slot_last) begin
                        if (bus.stop || !pick_found) begin
                            state <= ST_IDLE;
                        end else begin
                            sel_q        <= pick_nxt;
                            count        <= '0;
                            dwell_q      <= bus.dwell;
                            slot_start_q <= 1'b1;
                        end
                    end else begin
                        count <= count + 1'b1;
                        if (bus.stop) begin
                            state <= ST_LAST;
                        end
                    end
                end
                ST_LAST: begin
                    if (slot_last) begin
                        state <= ST_IDLE;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Sweep boundary is flagged even when stopping, as long as the successor would wrap
    assign bus.sweep_done = slot_last && pick_found && pick_wrapped;
    assign bus.sel        = sel_q;
    assign bus.busy       = busy;
    assign bus.slot_start = slot_start_q;

    pes_demux_1_8 u_demux (
        .sel (sel_q),
        .i   (bus.i & busy),
        .o0  (bus.o[0]),
        .o1  (bus.o[1]),
        .o2  (bus.o[2]),
        .o3  (bus.o[3]),
        .o4  (bus.o[4]),
        .o5  (bus.o[5]),
        .o6  (bus.o[6]),
        .o7  (bus.o[7])
    );

endmodule

// File: tb/tb_pes_demux_sequencer.sv
// Randomized scoreboard bench for pes_demux_sequencer against a slot-level reference model.
// Latency: expectations are pushed per cycle and checked on the falling edge.
// Backpressure: none.
module tb_pes_demux_sequencer;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    pes_demux_sequencer_if #(.DWELL_W(8)) bus ();

    pes_demux_sequencer #(.DWELL_W(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct packed {
        logic [2:0] sel;
        logic       busy;
        logic       slot_start;
        logic       sweep_done;
        logic [7:0] o;
    } exp_t;

    typedef struct {
        logic [7:0] mask;     // 0 with rand_mask=1 means: wander randomly
        bit         rand_mask;
        int         dmin;
        int         dmax;
        int         start_pct;
        int         stop_pct;
        int         chg_pct;
        int         rst_pct;
        int         cycles;
    } phase_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: the slot as seen from outside
    bit   m_busy;
    int   m_sel;
    int   m_left;      // cycles remaining in current slot, 1 on the last cycle
    bit   m_stopping;
    bit   m_first;
    logic [7:0] cur_mask;

    // Next enabled channel after cur, wrapping, cur itself last; -1 if none
    function automatic int next_ch(input logic [7:0] m, input int cur);
        for (int k = 1; k <= 8; k++) begin
            if (m[(cur + k) % 8]) return (cur + k) % 8;
        end
        return -1;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: the DUT presents outputs every cycle; compare against the queued expectation
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk("sel",        32'(bus.sel),        32'(e.sel));
            chk("busy",       32'(bus.busy),       32'(e.busy));
            chk("slot_start", 32'(bus.slot_start), 32'(e.slot_start));
            chk("sweep_done", 32'(bus.sweep_done), 32'(e.sweep_done));
            chk("o",          32'(bus.o),          32'(e.o));
        end
    end

    task automatic step(input bit rst, input bit st, input bit sp,
                        input logic [7:0] m, input logic [7:0] dw, input bit ii);
        exp_t e;
        int   nx;
        @(posedge clk);
        #1;
        reset       = rst;
        bus.start   = st;
        bus.stop    = sp;
        bus.chan_en = m;
        bus.dwell   = dw;
        bus.i       = ii;

        // Outputs during this cycle
        nx           = next_ch(m, m_sel);
        e.sel        = 3'(m_sel);
        e.busy       = m_busy;
        e.slot_start = m_first;
        e.o          = m_busy ? (8'(ii) << m_sel) : 8'h00;
        e.sweep_done = m_busy && (m_left == 1) && (nx >= 0) && (nx <= m_sel);
        exp_q.push_back(e);

        // What the next edge does
        if (rst) begin
            m_busy  = 1'b0;
            m_sel   = 0;
            m_first = 1'b0;
        end else if (!m_busy) begin
            m_first = 1'b0;
            if (st && m != 8'h00) begin
                m_busy     = 1'b1;
                m_sel      = next_ch(m, 7);
                m_left     = int'(dw) + 1;
                m_stopping = 1'b0;
                m_first    = 1'b1;
            end
        end else if (m_left == 1) begin
            if (m_stopping || sp || nx < 0) begin
                m_busy  = 1'b0;
                m_first = 1'b0;
            end else begin
                m_sel   = nx;
                m_left  = int'(dw) + 1;
                m_first = 1'b1;
            end
        end else begin
            m_left  = m_left - 1;
            m_first = 1'b0;
            if (sp) m_stopping = 1'b1;
        end
    endtask

    function automatic logic [7:0] rand_mask_val();
        case ($urandom_range(0, 3))
            0:       return 8'h00;
            1:       return 8'h01 << $urandom_range(0, 7);
            2:       return 8'hFF;
            default: return 8'($urandom);
        endcase
    endfunction

    phase_t phases[6];

    initial begin
        phases[0] = '{8'hFF,        1'b0, 0, 0, 100, 0,  0,  0, 40};
        phases[1] = '{8'b1010_0100, 1'b0, 3, 3, 50,  0,  0,  0, 60};
        phases[2] = '{8'b1010_0100, 1'b0, 3, 3, 30,  10, 0,  0, 300};
        phases[3] = '{8'h10,        1'b0, 0, 2, 50,  5,  0,  0, 120};
        phases[4] = '{8'h00,        1'b1, 0, 5, 30,  5,  10, 2, 2000};
        phases[5] = '{8'h00,        1'b0, 0, 3, 100, 0,  0,  0, 20};

        reset       = 1'b1;
        bus.start   = 1'b0;
        bus.stop    = 1'b0;
        bus.chan_en = 8'h00;
        bus.dwell   = 8'h00;
        bus.i       = 1'b0;
        m_busy      = 1'b0;
        m_sel       = 0;
        m_left      = 1;
        m_stopping  = 1'b0;
        m_first     = 1'b0;
        cur_mask    = 8'hFF;

        for (int p = 0; p < 6; p++) begin
            cur_mask = phases[p].mask;
            // Each phase opens with a reset so it starts from a known slot state
            step(1'b1, 1'b0, 1'b0, cur_mask, 8'h00, 1'b0);
            for (int c = 0; c < phases[p].cycles; c++) begin
                bit rst_b, st_b, sp_b, i_b;
                logic [7:0] dw;
                if (phases[p].rand_mask && ($urandom_range(0, 99) < phases[p].chg_pct))
                    cur_mask = rand_mask_val();
                rst_b = ($urandom_range(0, 99) < phases[p].rst_pct);
                st_b  = ($urandom_range(0, 99) < phases[p].start_pct);
                sp_b  = ($urandom_range(0, 99) < phases[p].stop_pct);
                i_b   = 1'($urandom);
                dw    = 8'($urandom_range(phases[p].dmin, phases[p].dmax));
                step(rst_b, st_b, sp_b, cur_mask, dw, i_b);
            end
        end

        @(posedge clk);
        @(negedge clk);
        #1;
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left, expected 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pes_demux_sequencer.md
# pes_demux_sequencer

Round-robin slot scheduler that drives the select of a 1-to-8 demultiplexer. It steps a serial input bit `i` through the enabled output channels, holding each channel for a programmable dwell time. It skips masked channels and reports slot and sweep boundaries. It sits directly in front of `pes_demux_1_8` and replaces free-running select counters in the datapath.

## Interface
Parameters:
- `DWELL_W`, default 8: width of the dwell count; slot length is `dwell`+1 cycles.

Ports:
- `clk`  in  1  single clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; sampled on the `clk` rising edge.
- `start`  in  1  begin sequencing; accepted only in IDLE.
- `stop`  in  1  finish the current slot, then return to IDLE; ignored in IDLE.
- `chan_en`  in  8  channel enable mask, bit k = channel k.
- `dwell`  in  DWELL_W  slot length minus one, latched at each slot start.
- `i`  in  1  data bit to route.
- `sel`  out  3  current channel (registered).
- `o`  out  8  demuxed outputs; `o[sel]` = `i` while busy, all other bits 0.
- `busy`  out  1  high in RUN and LAST.
- `slot_start`  out  1  one-cycle pulse in the first cycle of every slot.
- `sweep_done`  out  1  one-cycle pulse in the last cycle of a slot whose successor wraps.

## Operation
- **States:** IDLE, RUN, LAST.
- **Reset:** state IDLE; `sel`=0, count=0, `busy`=0, `slot_start`=0, `sweep_done`=0, `o`=0.
  - Applies the same way mid-slot; takes effect at the next edge.
- **IDLE → RUN:** on `start` with `chan_en` nonzero.
  - `sel` ← lowest set bit of `chan_en`.
  - Count ← 0.
  - Latch `dwell`.
- **Start with empty mask:** `start` with `chan_en`=0 is ignored; the block stays IDLE.
- **Slot:** lasts latched `dwell`+1 cycles; the count increments each cycle, and the slot ends in the cycle where count == latched dwell.
- **Next channel:** at slot end (RUN), the next channel is the first set bit of the current `chan_en` searching from `sel`+1 upward, wrapping 7→0, and including `sel` itself last.
  - Load it, reset the count, re-latch `dwell`, pulse `slot_start`.
- **Wrap:** if the next index ≤ current `sel` (wrap, or single-channel mask), `sweep_done` pulses in the slot's last cycle.
- **Mask cleared:** if `chan_en`=0 at slot end, go to IDLE; no `sweep_done`.
- **Stop:**
  - `stop` in RUN before the slot's last cycle → LAST; the current slot completes, then IDLE.
  - `stop` in the slot's last cycle → IDLE at the next edge.
  - `sweep_done` still pulses if that slot's successor would have wrapped.
- **Simultaneous `start`+`stop` in IDLE:** start taken, stop dropped.
- **Redundant commands:** `start` while busy is ignored; `stop` in LAST is ignored.
- **Sel in IDLE:** `sel` holds its last value.
- **Output gating:** `o` is forced 0 when not busy via gating of `i` (`i` & `busy`).
- **Arithmetic:**
  - Count is DWELL_W bits, unsigned, with no overflow, since count never exceeds the latched dwell.
  - `sel`+1 wraps modulo 8.

## Timing
- **Start latency:** `start` high in cycle N → `busy`=1, `slot_start`=1, new `sel` valid in N+1.
- **Slot boundary:** back-to-back slots have no gap; the last cycle of a slot is followed by the next slot's first cycle.
- **Data path:** `o` is combinational from `i` with zero latency.
  - `sel` and `busy` are registered, so channel switches align to clock edges.
- **Stop latency:** IDLE (`busy`=0) begins the cycle after the final slot's last cycle.
- **Mask and dwell sampling:**
  - `chan_en` is sampled only at `start` acceptance and at slot ends.
  - `dwell` is sampled only at slot starts.

## Structure
- Shared package `pes_demux_pkg`:
  - state encoding: IDLE=2'd0, RUN=2'd1, LAST=2'd2;
  - `NUM_CH`=8;
  - `SEL_W`=3.
- Sub-module `pes_demux_rr_pick`: a combinational next-enabled-channel finder.
  - Inputs: mask, current index.
  - Outputs: next index, found, wrapped.
  - Used both for the lowest-set-bit search at start and for successor search.
- Instantiate the existing `pes_demux_1_8` for the output demux, driven by `sel` and `i & busy`, with o0..o7 mapped to `o[0]`..`o[7]`.

## Test plan
- **Basic sweep:** reset, `chan_en`=8'hFF, `dwell`=0, pulse `start`.
  - `sel` 0,1,…,7,0 one per cycle; `slot_start` every cycle.
  - `sweep_done` high in the cycle `sel`=7.
- **Skipping with long dwell:** `chan_en`=8'b1010_0100, `dwell`=3.
  - `sel` sequence 2,5,7,2 with each held 4 cycles.
  - `sweep_done` in the 4th cycle of `sel`=7.
  - `o[sel]` tracks `i` toggling every cycle; other bits 0.
- **Stop handling:** `stop` in the 2nd cycle of a 4-cycle slot on `sel`=5.
  - Slot completes; `busy`=0 the next cycle; `sel` stays 5; `o`=0.
- **Stop at wrap:** `stop` in the last cycle of the `sel`=7 slot.
  - IDLE next cycle; `sweep_done` pulses.
- **Empty masks:**
  - `start` with `chan_en`=0 → stays IDLE, `busy`=0.
  - Clear the mask mid-slot → the current slot finishes, then IDLE with no `sweep_done`.
- **Reset mid-slot:** `reset` during `sel`=4, count=2.
  - Next cycle: `sel`=0, `busy`=0, `o`=0, `slot_start`=0.
  - A single-channel mask 8'h10 then gives `sel`=4 continuously with `sweep_done` every slot.
